// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;
  localparam int unsigned CntW      = 4;

  // Access sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } seq_state_e;

  // Which pipeline port owns the current access.
  typedef enum logic {
    OwnerIf   = 1'b0,
    OwnerData = 1'b1
  } owner_e;

  // Round-robin pick: a lone requester wins; on contention the port not granted last time wins.
  function automatic owner_e rr_pick(input logic if_req, input logic mem_req, input owner_e last);
    if (if_req && mem_req) begin
      return (last == OwnerData) ? OwnerIf : OwnerData;
    end else if (mem_req) begin
      return OwnerData;
    end else begin
      return OwnerIf;
    end
  endfunction

endpackage

// File: rtl/sram_port_arbiter_access_seq.sv
// SRAM strobe sequencer: steps one read or write through the strobe timing and reports completion.
module sram_port_arbiter_access_seq
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,    // only honoured while idle_o
  input  logic we_i,       // 1 = write access
  output logic idle_o,
  output logic sample_o,   // last read cycle: capture SRAM data this edge
  output logic done_o,     // access finishes this edge, ack goes out next cycle
  output logic ce_n_o,
  output logic oe_n_o,
  output logic we_n_o,
  output logic dout_en_o
);

  localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT_CYCLES);

  seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dout_en_q, dout_en_d;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_o = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (we_i) begin
            state_d = StWrSetup;
          end else begin
            state_d = StRead;
            cnt_d   = WaitCnt;
          end
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          sample_o = 1'b1;
          done_o   = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = WaitCnt;
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrHold: begin
        done_o  = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    dout_en_d = 1'b0;
    unique case (state_d)
      StRead: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      StWrSetup, StWrHold: begin
        ce_n_d    = 1'b0;
        dout_en_d = 1'b1;
      end
      StWrPulse: begin
        ce_n_d    = 1'b0;
        we_n_d    = 1'b0;
        dout_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and strobe registers; reset releases the bus immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign idle_o    = (state_q == StIdle);
  assign ce_n_o    = ce_n_q;
  assign oe_n_o    = oe_n_q;
  assign we_n_o    = we_n_q;
  assign dout_en_o = dout_en_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one external SRAM between the fetch and memory stages with round-robin arbitration.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = SramAddrW,
  parameter int unsigned DATA_W      = SramDataW,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_if,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  logic   seq_idle, seq_sample, seq_done;
  logic   start, start_we;
  owner_e gnt_owner;
  owner_e owner_q, owner_d, last_grant_q, last_grant_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;

  // Arbitration: only evaluated while the sequencer is idle.
  always_comb begin
    gnt_owner = rr_pick(if_req, mem_req, last_grant_q);
    start     = seq_idle & (if_req | mem_req);
    start_we  = (gnt_owner == OwnerData) & mem_we;
  end

  // Latch the granted request and route read data / acks back to the owner.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if (start) begin
      owner_d      = gnt_owner;
      last_grant_d = gnt_owner;
      addr_d       = (gnt_owner == OwnerData) ? mem_addr : if_addr;
      if (start_we) begin
        dout_d = mem_wdata;
      end
    end
    if (seq_sample) begin
      if (owner_q == OwnerIf) begin
        if_rdata_d = sram_din;
      end else begin
        mem_rdata_d = sram_din;
      end
    end
    if (seq_done) begin
      if (owner_q == OwnerIf) begin
        if_ack_d = 1'b1;
      end else begin
        mem_ack_d = 1'b1;
      end
    end
  end

  // Arbiter and return-path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OwnerIf;
      last_grant_q <= OwnerData;
      addr_q       <= '0;
      dout_q       <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
    end
  end

  sram_port_arbiter_access_seq #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_seq (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (start),
    .we_i     (start_we),
    .idle_o   (seq_idle),
    .sample_o (seq_sample),
    .done_o   (seq_done),
    .ce_n_o   (sram_ce_n),
    .oe_n_o   (sram_oe_n),
    .we_n_o   (sram_we_n),
    .dout_en_o(sram_dout_en)
  );

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  // Fetch stalls until its ack cycle.
  assign stall_if  = if_req & ~if_ack_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, latency and memory contents.
module tb_sram_port_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int W  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, sram_din;

  logic [DW-1:0] if_rdata, mem_rdata, sram_dout;
  logic [AW-1:0] sram_addr;
  logic if_ack, mem_ack, stall_if, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

  logic [DW-1:0] w0_if_rdata, w0_mem_rdata, w0_sram_dout;
  logic [AW-1:0] w0_sram_addr;
  logic w0_if_ack, w0_mem_ack, w0_stall_if, w0_dout_en, w0_ce_n, w0_oe_n, w0_we_n;
  logic [DW-1:0] w3_if_rdata, w3_mem_rdata, w3_sram_dout;
  logic [AW-1:0] w3_sram_addr;
  logic w3_if_ack, w3_mem_ack, w3_stall_if, w3_dout_en, w3_ce_n, w3_oe_n, w3_we_n;

  int vectors    = 0;
  int miscompares = 0;
  int ovl_errs   = 0;

  // SRAM model (512 words, low address bits) and the bench's expected memory contents.
  logic [DW-1:0] sram_arr [512];
  logic [DW-1:0] ref_mem  [512];
  logic          mem_inited = 1'b0;
  logic          din_ovr_en;
  logic [DW-1:0] din_ovr;

  function automatic logic [DW-1:0] init_word(input int a);
    return 16'(a * 40503 + 12345) ^ 16'h5A5A;
  endfunction

  assign sram_din = din_ovr_en ? din_ovr : sram_arr[sram_addr[8:0]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 512; i++) sram_arr[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n && sram_dout_en) begin
      sram_arr[sram_addr[8:0]] <= sram_dout;
    end
  end

  // Strobe overlap watch on every instance.
  always @(negedge clk) begin
    if ((!sram_oe_n && !sram_we_n) || (sram_dout_en && !sram_oe_n) ||
        (!w0_oe_n && !w0_we_n) || (w0_dout_en && !w0_oe_n) ||
        (!w3_oe_n && !w3_we_n) || (w3_dout_en && !w3_oe_n)) begin
      ovl_errs++;
      $display("FAIL strobe_overlap at %0t: oe_n/we_n/dout_en main=%b%b%b w0=%b%b%b w3=%b%b%b",
               $time, sram_oe_n, sram_we_n, sram_dout_en, w0_oe_n, w0_we_n, w0_dout_en,
               w3_oe_n, w3_we_n, w3_dout_en);
    end
  end

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_if(stall_if),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(w0_if_rdata), .if_ack(w0_if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(w0_mem_rdata), .mem_ack(w0_mem_ack), .stall_if(w0_stall_if),
    .sram_addr(w0_sram_addr), .sram_dout(w0_sram_dout), .sram_dout_en(w0_dout_en),
    .sram_din(sram_din), .sram_ce_n(w0_ce_n), .sram_oe_n(w0_oe_n), .sram_we_n(w0_we_n)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(w3_if_rdata), .if_ack(w3_if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(w3_mem_rdata), .mem_ack(w3_mem_ack), .stall_if(w3_stall_if),
    .sram_addr(w3_sram_addr), .sram_dout(w3_sram_dout), .sram_dout_en(w3_dout_en),
    .sram_din(sram_din), .sram_ce_n(w3_ce_n), .sram_oe_n(w3_oe_n), .sram_we_n(w3_we_n)
  );

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with reset released and no requests.
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; din_ovr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, if_ack, mem_ack} !== 6'b111000) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 111000",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, if_ack, mem_ack});
    end
    vectors++;
    if ({if_rdata, mem_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata, mem_rdata});
    end
    vectors++;
    if ({sram_addr, sram_dout} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_addr_dout: got %h want 0", {sram_addr, sram_dout});
    end
    if_req = 1'b1;
    #1;
    vectors++;
    if (stall_if !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall_hi: got %b want 1", stall_if);
    end
    if_req = 1'b0;
    #1;
    vectors++;
    if (stall_if !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall_lo: got %b want 0", stall_if);
    end
  endtask

  task automatic test_fetch_only;
    int ack_c, oe_lo, stall_bad, mem_seen;
    logic [DW-1:0] rd;
    do_reset();
    ack_c = 0; oe_lo = 0; stall_bad = 0; mem_seen = 0; rd = '0;
    din_ovr_en = 1'b1; din_ovr = 16'hE14D;
    if_addr = 18'h00003; if_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (!sram_oe_n) oe_lo++;
      if (mem_ack) mem_seen++;
      if (stall_if !== (c < W + 2)) stall_bad++;
      if (if_ack && ack_c == 0) begin
        ack_c = c; rd = if_rdata; if_req = 1'b0;
      end
    end
    din_ovr_en = 1'b0;
    vectors++;
    if (ack_c !== W + 2) begin
      miscompares++; $display("FAIL fetch_latency: got %0d want %0d", ack_c, W + 2);
    end
    vectors++;
    if (rd !== 16'hE14D) begin
      miscompares++; $display("FAIL fetch_rdata: got %h want e14d", rd);
    end
    vectors++;
    if (oe_lo !== W + 1) begin
      miscompares++; $display("FAIL fetch_oe_cycles: got %0d want %0d", oe_lo, W + 1);
    end
    vectors++;
    if (mem_seen !== 0 || stall_bad !== 0) begin
      miscompares++;
      $display("FAIL fetch_side: mem_ack seen %0d, stall errs %0d, want 0/0", mem_seen, stall_bad);
    end
  endtask

  task automatic test_store;
    int ack_c, we_lo, den, pulse_bad, if_seen;
    do_reset();
    ack_c = 0; we_lo = 0; den = 0; pulse_bad = 0; if_seen = 0;
    mem_we = 1'b1; mem_addr = 18'h00010; mem_wdata = 16'hBEEF; mem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (!sram_we_n) begin
        we_lo++;
        if (!sram_dout_en || sram_dout !== 16'hBEEF || sram_addr !== 18'h00010) pulse_bad++;
      end
      if (sram_dout_en) den++;
      if (if_ack) if_seen++;
      if (mem_ack && ack_c == 0) begin
        ack_c = c; mem_req = 1'b0; mem_we = 1'b0;
      end
    end
    ref_mem[16] = 16'hBEEF;
    vectors++;
    if (we_lo !== W + 1) begin
      miscompares++; $display("FAIL store_we_cycles: got %0d want %0d", we_lo, W + 1);
    end
    vectors++;
    if (den !== W + 3 || pulse_bad !== 0) begin
      miscompares++;
      $display("FAIL store_dout_en: got %0d cycles (%0d bad pulse) want %0d", den, pulse_bad, W + 3);
    end
    vectors++;
    if (ack_c !== W + 4 || if_seen !== 0) begin
      miscompares++;
      $display("FAIL store_latency: got %0d (if_ack %0d) want %0d", ack_c, if_seen, W + 4);
    end
    vectors++;
    if (sram_arr[16] !== 16'hBEEF) begin
      miscompares++; $display("FAIL store_sram_word: got %h want beef", sram_arr[16]);
    end
  endtask

  task automatic test_contention;
    int if_c, mem_c;
    logic [DW-1:0] if_d, mem_d;
    do_reset();
    if_c = 0; mem_c = 0; if_d = '0; mem_d = '0;
    if_addr = 18'h00021; mem_addr = 18'h00042; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (if_ack && if_c == 0) begin if_c = c; if_d = if_rdata; if_req = 1'b0; end
      if (mem_ack && mem_c == 0) begin mem_c = c; mem_d = mem_rdata; mem_req = 1'b0; end
    end
    vectors++;
    if (if_c !== W + 2 || mem_c !== 2 * W + 5) begin
      miscompares++;
      $display("FAIL contention_order: if_ack@%0d mem_ack@%0d want %0d/%0d",
               if_c, mem_c, W + 2, 2 * W + 5);
    end
    vectors++;
    if (if_d !== ref_mem[9'h021] || mem_d !== ref_mem[9'h042]) begin
      miscompares++;
      $display("FAIL contention_data: got %h/%h want %h/%h", if_d, mem_d,
               ref_mem[9'h021], ref_mem[9'h042]);
    end
  endtask

  task automatic test_back_to_back;
    int n, last_own, alt_bad, data_bad;
    do_reset();
    n = 0; last_own = -1; alt_bad = 0; data_bad = 0;
    if_addr = 18'($urandom_range(0, 255)); mem_addr = 18'($urandom_range(0, 255));
    mem_we = 1'b0; if_req = 1'b1; mem_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (if_ack && mem_ack) alt_bad++;
      if (if_ack) begin
        n++;
        if (last_own == 0) alt_bad++;
        last_own = 0;
        if (if_rdata !== ref_mem[if_addr[8:0]]) data_bad++;
        if_addr = 18'($urandom_range(0, 255));
      end
      if (mem_ack) begin
        n++;
        if (last_own == 1) alt_bad++;
        last_own = 1;
        if (mem_rdata !== ref_mem[mem_addr[8:0]]) data_bad++;
        mem_addr = 18'($urandom_range(0, 255));
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    vectors++;
    if (n !== 10 || alt_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_alternate: %0d acks, %0d order errs; want 10 acks, 0 errs", n, alt_bad);
    end
    vectors++;
    if (data_bad !== 0) begin
      miscompares++; $display("FAIL b2b_data: got %0d bad reads want 0", data_bad);
    end
  endtask

  task automatic test_reset_mid_write;
    int ack_seen, ack_c;
    logic [DW-1:0] rd;
    do_reset();
    ack_seen = 0; ack_c = 0; rd = '0;
    mem_we = 1'b1; mem_addr = 18'h001F0; mem_wdata = 16'h1234; mem_req = 1'b1;
    repeat (2) next_cycle();
    vectors++;
    if (sram_we_n !== 1'b0) begin
      miscompares++; $display("FAIL abort_in_pulse: we_n got %b want 0", sram_we_n);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dout_en} !== 4'b1110) begin
      miscompares++;
      $display("FAIL abort_async: we_n/ce_n/oe_n/dout_en got %b want 1110",
               {sram_we_n, sram_ce_n, sram_oe_n, sram_dout_en});
    end
    mem_req = 1'b0; mem_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b1;
      if (mem_ack || if_ack) ack_seen++;
    end
    vectors++;
    if (ack_seen !== 0) begin
      miscompares++; $display("FAIL abort_no_ack: got %0d acks want 0", ack_seen);
    end
    mem_addr = 18'h00020; mem_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (mem_ack && ack_c == 0) begin ack_c = c; rd = mem_rdata; mem_req = 1'b0; end
    end
    vectors++;
    if (ack_c !== W + 2 || rd !== ref_mem[9'h020]) begin
      miscompares++;
      $display("FAIL abort_recover: ack@%0d data %h want ack@%0d data %h",
               ack_c, rd, W + 2, ref_mem[9'h020]);
    end
  endtask

  task automatic test_wait_sweep;
    int r0, r1, r3, s0, s1, s3, dbad;
    do_reset();
    r0 = 0; r1 = 0; r3 = 0; s0 = 0; s1 = 0; s3 = 0; dbad = 0;
    if_addr = 18'h00033; if_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (w0_if_ack && r0 == 0) begin r0 = c; if (w0_if_rdata !== ref_mem[9'h033]) dbad++; end
      if (if_ack && r1 == 0)    begin r1 = c; if (if_rdata !== ref_mem[9'h033]) dbad++; end
      if (w3_if_ack && r3 == 0) begin r3 = c; if (w3_if_rdata !== ref_mem[9'h033]) dbad++; end
    end
    if_req = 1'b0;
    vectors++;
    if (r0 !== 2 || r1 !== 3 || r3 !== 5 || dbad !== 0) begin
      miscompares++;
      $display("FAIL sweep_read: latency W0/W1/W3 %0d/%0d/%0d (%0d bad data) want 2/3/5",
               r0, r1, r3, dbad);
    end
    do_reset();
    mem_we = 1'b1; mem_addr = 18'h001F8; mem_wdata = 16'hA5C3; mem_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (w0_mem_ack && s0 == 0) s0 = c;
      if (mem_ack && s1 == 0)    s1 = c;
      if (w3_mem_ack && s3 == 0) s3 = c;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    vectors++;
    if (s0 !== 4 || s1 !== 5 || s3 !== 7) begin
      miscompares++;
      $display("FAIL sweep_write: latency W0/W1/W3 %0d/%0d/%0d want 4/5/7", s0, s1, s3);
    end
  endtask

  // Randomized traffic against a transaction model: grant when free, round-robin on contention,
  // ack L-1 edges after grant, next grant no earlier than L+1 edges after grant.
  task automatic test_random;
    int next_free, last, m_own, m_ack_edge, lat;
    logic m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic exp_if, exp_mem;
    do_reset();
    next_free = 1; last = 1; m_own = 0; m_ack_edge = -1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      if (k >= next_free && (if_req || mem_req)) begin
        if (if_req && mem_req) m_own = 1 - last;
        else                   m_own = mem_req ? 1 : 0;
        last       = m_own;
        m_we       = (m_own == 1) && mem_we;
        m_addr     = (m_own == 1) ? mem_addr : if_addr;
        m_wdata    = mem_wdata;
        lat        = m_we ? W + 4 : W + 2;
        m_ack_edge = k + lat - 1;
        next_free  = k + lat + 1;
      end
      @(negedge clk);
      exp_if  = (m_ack_edge == k) && (m_own == 0);
      exp_mem = (m_ack_edge == k) && (m_own == 1);
      vectors++;
      if (if_ack !== exp_if || mem_ack !== exp_mem) begin
        miscompares++;
        $display("FAIL rand_ack k=%0d: if/mem ack got %b%b want %b%b",
                 k, if_ack, mem_ack, exp_if, exp_mem);
      end
      vectors++;
      if (stall_if !== (if_req && !exp_if)) begin
        miscompares++;
        $display("FAIL rand_stall k=%0d: got %b want %b", k, stall_if, if_req && !exp_if);
      end
      if (exp_if) begin
        vectors++;
        if (if_rdata !== ref_mem[m_addr[8:0]]) begin
          miscompares++;
          $display("FAIL rand_if_rdata a=%h: got %h want %h", m_addr, if_rdata,
                   ref_mem[m_addr[8:0]]);
        end
      end
      if (exp_mem && m_we) ref_mem[m_addr[8:0]] = m_wdata;
      if (exp_mem && !m_we) begin
        vectors++;
        if (mem_rdata !== ref_mem[m_addr[8:0]]) begin
          miscompares++;
          $display("FAIL rand_mem_rdata a=%h: got %h want %h", m_addr, mem_rdata,
                   ref_mem[m_addr[8:0]]);
        end
      end
      // Requester agents; pending requests may wiggle their payload, which must not leak in.
      if (if_ack) begin
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = 18'($urandom_range(0, 255));
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 18'($urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        if_addr = 18'($urandom_range(0, 255));
      end
      if (mem_ack) begin
        mem_req = ($urandom_range(0, 1) == 1);
        mem_we = ($urandom_range(0, 1) == 1);
        mem_addr = 18'($urandom_range(0, 255));
        mem_wdata = 16'($urandom);
      end else if (!mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          mem_req = 1'b1; mem_we = ($urandom_range(0, 1) == 1);
          mem_addr = 18'($urandom_range(0, 255)); mem_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_we = ($urandom_range(0, 1) == 1);
        mem_addr = 18'($urandom_range(0, 255)); mem_wdata = 16'($urandom);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  task automatic test_strobe_overlap;
    vectors++;
    if (ovl_errs !== 0) begin
      miscompares++; $display("FAIL strobe_overlap_total: got %0d want 0", ovl_errs);
    end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; din_ovr_en = 1'b0; din_ovr = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_only();
    test_store();
    test_contention();
    test_back_to_back();
    test_reset_mid_write();
    test_wait_sweep();
    test_random();
    test_strobe_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
